// File: rtl/cpu_ula_pkg.sv
// Shared opcode and FSM state definitions for the sequential ALU and its multiplier.
package cpu_ula_pkg;

    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_ADDI = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_SUBI = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CALC   = 2'd1,
        S_MUL    = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    function automatic logic is_legal_op(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_ADDI) || (op == OP_SUB) ||
               (op == OP_SUBI) || (op == OP_MUL);
    endfunction

endpackage

// File: rtl/cpu_ula_mul_iter.sv
// Iterative shift-add multiplier, one multiplier bit per clock, WIDTH iterations after load.
module cpu_ula_mul_iter #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic                 o_done,
    output logic [2*WIDTH-1:0]   o_product
);

    localparam int CW = $clog2(WIDTH);

    logic                 r_run;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;

    logic [2*WIDTH-1:0]   w_acc_nxt;
    logic                 w_last;

    assign w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_last    = r_run && (r_cnt == CW'(WIDTH - 1));

    // o_done marks the edge that performs the final iteration, so the
    // product presented alongside it already includes that last step.
    assign o_done    = w_last;
    assign o_product = w_acc_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run    <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (i_start) begin
            r_run    <= 1'b1;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, i_a};
            r_mplier <= i_b;
        end else if (r_run) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CW'(1);
            if (w_last) r_run <= 1'b0;
        end
    end

endmodule

// File: rtl/cpu_ula_seq.sv
// Handshaked ALU: single-cycle add/sub family plus iterative MUL, registered result and flags.
module cpu_ula_seq
    import cpu_ula_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int IMM_WIDTH = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        op_code,
    input  logic [WIDTH-1:0]  src1,
    input  logic [WIDTH-1:0]  src2,
    output logic              busy,
    output logic              done,
    output logic              illegal_op,
    output logic [WIDTH-1:0]  op_result,
    output logic              zero,
    output logic              carry,
    output logic              overflow
);

    state_t r_state, w_next;

    logic [WIDTH-1:0] r_a, r_b;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_res;
    logic             r_zero, r_carry, r_ovf, r_illegal;

    logic             w_accept, w_legal, w_mul_start, w_mul_done;
    logic [2*WIDTH-1:0] w_mul_prod;
    logic [WIDTH-1:0] w_imm, w_opb, w_as_res;
    logic [WIDTH:0]   w_sum;
    logic             w_sign, w_is_imm, w_is_sub, w_as_carry, w_as_ovf;

    assign w_accept    = start && (r_state == S_IDLE || r_state == S_FINISH);
    assign w_legal     = is_legal_op(op_code);
    assign w_mul_start = w_accept && w_legal && (op_code == OP_MUL);

    cpu_ula_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .rst       (rst),
        .i_start   (w_mul_start),
        .i_a       (src1),
        .i_b       (src2),
        .o_done    (w_mul_done),
        .o_product (w_mul_prod)
    );

    // Sign-magnitude immediate: the sign flips the direction of ADDI/SUBI.
    assign w_imm    = {{(WIDTH-IMM_WIDTH+1){1'b0}}, r_b[IMM_WIDTH-2:0]};
    assign w_sign   = r_b[IMM_WIDTH-1];
    assign w_is_imm = (r_op == OP_ADDI) || (r_op == OP_SUBI);
    assign w_is_sub = (r_op == OP_SUB) || (r_op == OP_ADDI && w_sign) ||
                      (r_op == OP_SUBI && !w_sign);
    assign w_opb    = w_is_imm ? w_imm : r_b;
    assign w_sum    = w_is_sub ? ({1'b0, r_a} - {1'b0, w_opb})
                               : ({1'b0, r_a} + {1'b0, w_opb});
    assign w_as_res   = w_sum[WIDTH-1:0];
    assign w_as_carry = w_sum[WIDTH];
    assign w_as_ovf   = w_is_sub
        ? ((r_a[WIDTH-1] != w_opb[WIDTH-1]) && (w_as_res[WIDTH-1] != r_a[WIDTH-1]))
        : ((r_a[WIDTH-1] == w_opb[WIDTH-1]) && (w_as_res[WIDTH-1] != r_a[WIDTH-1]));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_FINISH: begin
                if (start)
                    w_next = !w_legal ? S_IDLE : ((op_code == OP_MUL) ? S_MUL : S_CALC);
                else
                    w_next = S_IDLE;
            end
            S_CALC:  w_next = S_FINISH;
            S_MUL:   if (w_mul_done) w_next = S_FINISH;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == S_CALC) || (r_state == S_MUL);
        done = (r_state == S_FINISH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a       <= '0;
            r_b       <= '0;
            r_op      <= '0;
            r_res     <= '0;
            r_zero    <= 1'b0;
            r_carry   <= 1'b0;
            r_ovf     <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_illegal <= w_accept && !w_legal;
            if (w_accept && w_legal) begin
                r_a  <= src1;
                r_b  <= src2;
                r_op <= op_code;
            end
            if (r_state == S_CALC) begin
                r_res   <= w_as_res;
                r_zero  <= (w_as_res == '0);
                r_carry <= w_as_carry;
                r_ovf   <= w_as_ovf;
            end else if (r_state == S_MUL && w_mul_done) begin
                r_res   <= w_mul_prod[WIDTH-1:0];
                r_zero  <= (w_mul_prod[WIDTH-1:0] == '0);
                r_carry <= |w_mul_prod[2*WIDTH-1:WIDTH];
                r_ovf   <= 1'b0;
            end
        end
    end

    assign op_result  = r_res;
    assign zero       = r_zero;
    assign carry      = r_carry;
    assign overflow   = r_ovf;
    assign illegal_op = r_illegal;

endmodule

// File: tb/tb_cpu_ula_seq.sv
// Randomized self-checking bench for cpu_ula_seq against an arithmetic reference model.
module tb_cpu_ula_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op_code = 3'd0;
    logic [15:0] src1 = '0, src2 = '0;
    logic        busy, done, illegal_op, zero, carry, overflow;
    logic [15:0] op_result;

    int n_chk = 0;
    int n_err = 0;

    logic [15:0] exp_res = '0;
    logic        exp_z = 1'b0, exp_c = 1'b0, exp_v = 1'b0;

    cpu_ula_seq #(.WIDTH(16), .IMM_WIDTH(7)) dut (
        .clk(clk), .rst(rst), .start(start), .op_code(op_code),
        .src1(src1), .src2(src2), .busy(busy), .done(done),
        .illegal_op(illegal_op), .op_result(op_result), .zero(zero),
        .carry(carry), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] r, output logic c, output logic v);
        int     sa, sb, full, s;
        longint p;
        bit     sub;
        logic [15:0] opb;
        if (op == 3'd5) begin
            p = longint'(a) * longint'(b);
            r = 16'(p % 65536);
            c = (p > 65535);
            v = 1'b0;
            return;
        end
        opb = b;
        sub = (op == 3'd3);
        if (op == 3'd2 || op == 3'd4) begin
            opb = b & 16'h003F;
            sub = (op == 3'd4) ^ b[6];
        end
        sa = int'($signed(a));
        sb = int'($signed(opb));
        if (sub) begin
            full = int'(a) - int'(opb);
            c    = (a < opb);
            s    = sa - sb;
        end else begin
            full = int'(a) + int'(opb);
            c    = (full > 65535);
            s    = sa + sb;
        end
        r = 16'(full);
        v = (s > 32767) || (s < -32768);
    endfunction

    // inj >= 0 pulses an ADD start that many cycles into the busy window.
    task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b, input int inj);
        logic [15:0] mr;
        logic        mc, mv;
        int          lat;
        @(negedge clk);
        start = 1'b1; op_code = op; src1 = a; src2 = b;
        @(negedge clk);
        start = 1'b0;
        if (!(op inside {3'd1, 3'd2, 3'd3, 3'd4, 3'd5})) begin
            chk("ill_pulse", illegal_op, 1'b1);
            chk("ill_nodone", {busy, done}, 2'b00);
            @(negedge clk);
            chk("ill_clear", illegal_op, 1'b0);
            chk("ill_hold", {op_result, zero, carry, overflow, done}, {exp_res, exp_z, exp_c, exp_v, 1'b0});
            return;
        end
        model(op, a, b, mr, mc, mv);
        chk("busy", busy, 1'b1);
        chk("hold", op_result, exp_res);
        lat = 0;
        while (!done && lat < 40) begin
            if (lat == inj) begin
                start = 1'b1; op_code = 3'd1; src1 = 16'h0001; src2 = 16'h0001;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        chk("latency", lat, (op == 3'd5) ? 16 : 1);
        chk("done", done, 1'b1);
        chk("result", op_result, mr);
        chk("flags", {zero, carry, overflow}, {(mr == 16'h0), mc, mv});
        exp_res = mr; exp_z = (mr == 16'h0); exp_c = mc; exp_v = mv;
        @(negedge clk);
        chk("done_pulse", done, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dcnt;
        logic [2:0]  rop;
        logic [15:0] ra, rb;

        #12;
        chk("reset_out", {op_result, zero, carry, overflow, done, busy, illegal_op}, '0);
        @(negedge clk);
        rst = 1'b0;

        run_op(3'd1, 16'hFFFF, 16'h0001, -1);
        run_op(3'd2, 16'd10, 16'hFF83, -1);
        run_op(3'd4, 16'd10, 16'hFF83, -1);
        run_op(3'd2, 16'd10, 16'hFFC3, -1);
        run_op(3'd4, 16'd10, 16'hFFC3, -1);
        run_op(3'd3, 16'd5, 16'd7, -1);
        run_op(3'd3, 16'h8000, 16'h0001, -1);
        run_op(3'd5, 16'd300, 16'd300, 5);
        run_op(3'd0, 16'h1234, 16'h5678, -1);

        // back-to-back: second start lands in the FINISH cycle of the first
        @(negedge clk);
        start = 1'b1; op_code = 3'd1; src1 = 16'd2; src2 = 16'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("b2b_done1", done, 1'b1);
        chk("b2b_res1", op_result, 16'd5);
        start = 1'b1; op_code = 3'd3; src1 = 16'd9; src2 = 16'd4;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_gap", {done, busy}, 2'b01);
        @(negedge clk);
        chk("b2b_done2", done, 1'b1);
        chk("b2b_res2", op_result, 16'd5);
        @(negedge clk);
        chk("b2b_end", done, 1'b0);

        // asynchronous reset in the middle of a multiply
        start = 1'b1; op_code = 3'd5; src1 = 16'd1234; src2 = 16'd77;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("async_rst", {op_result, zero, carry, overflow, done, busy, illegal_op}, '0);
        dcnt = 0;
        repeat (5) begin @(negedge clk); if (done) dcnt++; end
        rst = 1'b0;
        repeat (20) begin @(negedge clk); if (done) dcnt++; end
        chk("rst_nodone", dcnt, 0);
        exp_res = '0; exp_z = 1'b0; exp_c = 1'b0; exp_v = 1'b0;
        run_op(3'd1, 16'd1, 16'd1, -1);

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = ($urandom_range(0, 4) == 0) ? 16'h8000 : 16'($urandom);
            rb  = ($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'($urandom);
            run_op(rop, ra, rb, ($urandom_range(0, 1) == 0) ? -1 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
